// File: rtl/tpu_ctrl_pkg.sv
// tpu_ctrl_pkg: shared drain FSM state type, counter sizing helper and default array size
package tpu_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, DRAIN, FINISH} drain_state_t;

    localparam int DEFAULT_ARRAY_DIM = 16;

    function automatic int cnt_width(input int start_delay, input int array_dim, input int rows_max);
        return $clog2(start_delay + array_dim + rows_max + 1);
    endfunction

endpackage

// File: rtl/drain_col_window.sv
// drain_col_window: write-enable window for one output column, lo <= t < lo + rows
module drain_col_window
    import tpu_ctrl_pkg::*;
#(
    parameter int K           = 0,
    parameter int START_DELAY = 16,
    parameter int NW          = 5,
    parameter int CW          = 6
) (
    input  logic          active_i,
    input  logic          stg_i,
    input  logic [NW-1:0] rows_i,
    input  logic [CW-1:0] t_i,
    output logic          en_o
);

    logic [CW-1:0] lo;
    logic [CW-1:0] hi;

    // column K opens K cycles after column 0 in staggered mode, together with it in flat mode
    always_comb begin
        lo   = CW'(START_DELAY) + (stg_i ? CW'(K) : '0);
        hi   = lo + CW'(rows_i);
        en_o = active_i && (t_i >= lo) && (t_i < hi);
    end

endmodule

// File: rtl/mmu_drain_control.sv
// mmu_drain_control: staggered per-column write enables draining MMU results into output FIFOs
// Optional overflow checker enabled by defining MMU_DRAIN_OVF_CHK_EN (adds fifo_full / ovf_err).
module mmu_drain_control
    import tpu_ctrl_pkg::*;
#(
    parameter int  ARRAY_DIM   = DEFAULT_ARRAY_DIM,
    parameter int  ROWS_MAX    = 16,
    parameter int  START_DELAY = 16,
    localparam int NW          = $clog2(ROWS_MAX + 1),
    localparam int CW          = cnt_width(START_DELAY, ARRAY_DIM, ROWS_MAX)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NW-1:0]        num_rows,
    input  logic                 stagger,
    output logic                 busy,
    output logic [ARRAY_DIM-1:0] wr_en,
    output logic                 done
`ifdef MMU_DRAIN_OVF_CHK_EN
    ,
    input  logic                 fifo_full [ARRAY_DIM],
    output logic                 ovf_err
`endif
);

    drain_state_t         state_q, state_d;
    logic [CW-1:0]        t_q, t_d, t_end;
    logic [NW-1:0]        rows_q, rows_d;
    logic                 stg_q, stg_d;
    logic                 accept, active_d;
    logic                 busy_q, done_q;
    logic [ARRAY_DIM-1:0] wr_en_q, win_d;

    // accept a drain from IDLE or FINISH, advance t, and pick the next state from next-cycle t
    always_comb begin
        accept   = start && (state_q != DRAIN);
        rows_d   = accept ? ((num_rows > NW'(ROWS_MAX)) ? NW'(ROWS_MAX) : num_rows) : rows_q;
        stg_d    = accept ? stagger : stg_q;
        t_d      = accept ? '0 : ((state_q == DRAIN) ? t_q + CW'(1) : t_q);
        t_end    = CW'(START_DELAY) + (stg_d ? CW'(ARRAY_DIM - 1) : '0) + CW'(rows_d);
        state_d  = (accept || state_q == DRAIN) ? ((t_d == t_end) ? FINISH : DRAIN) : IDLE;
        active_d = (state_d == DRAIN);
    end

    for (genvar k = 0; k < ARRAY_DIM; k++) begin : g_col
        drain_col_window #(
            .K          (k),
            .START_DELAY(START_DELAY),
            .NW         (NW),
            .CW         (CW)
        ) u_win (
            .active_i(active_d),
            .stg_i   (stg_d),
            .rows_i  (rows_d),
            .t_i     (t_d),
            .en_o    (win_d[k])
        );
    end

    // state, drain parameters and registered outputs, all derived from next-cycle values
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            t_q     <= '0;
            rows_q  <= '0;
            stg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wr_en_q <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            rows_q  <= rows_d;
            stg_q   <= stg_d;
            busy_q  <= active_d;
            done_q  <= (state_d == FINISH);
            wr_en_q <= win_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign wr_en = wr_en_q;

`ifdef MMU_DRAIN_OVF_CHK_EN
    logic [ARRAY_DIM-1:0] full_v;
    logic                 ovf_q, ovf_d;

    // sticky flag for a write into a full FIFO; a newly accepted drain clears it
    always_comb begin
        full_v = '0;
        for (int i = 0; i < ARRAY_DIM; i++) full_v[i] = fifo_full[i];
        ovf_d = accept ? 1'b0 : (ovf_q | (|(wr_en_q & full_v)));
    end

    // overflow flag register
    always_ff @(posedge clk) begin
        if (reset) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign ovf_err = ovf_q;
`endif

endmodule

// File: tb/tb_mmu_drain_control.sv
// tb_mmu_drain_control: directed checks of the drain sequencer (ARRAY_DIM=4, ROWS_MAX=8, START_DELAY=2)
module tb_mmu_drain_control;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] num_rows;
    logic       stagger;
    logic       busy;
    logic [3:0] wr_en;
    logic       done;
`ifdef MMU_DRAIN_OVF_CHK_EN
    logic       fifo_full [4];
    logic       ovf_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mmu_drain_control #(
        .ARRAY_DIM  (4),
        .ROWS_MAX   (8),
        .START_DELAY(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .num_rows (num_rows),
        .stagger  (stagger),
        .busy     (busy),
        .wr_en    (wr_en),
        .done     (done)
`ifdef MMU_DRAIN_OVF_CHK_EN
        ,
        .fifo_full(fifo_full),
        .ovf_err  (ovf_err)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_wr(input int t, input int rows, input int stg);
        logic [3:0] e;
        e = '0;
        for (int k = 0; k < 4; k++) e[k] = (t >= 2 + k * stg) && (t < 2 + k * stg + rows);
        return e;
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; num_rows = '0; stagger = 1'b0;
`ifdef MMU_DRAIN_OVF_CHK_EN
        for (int k = 0; k < 4; k++) fifo_full[k] = 1'b0;
`endif
        step(); step();
        total++;
        if ({busy, wr_en, done} !== 6'b0) begin
            bad++;
            $display("FAIL reset busy/wr_en/done got=%b exp=000000", {busy, wr_en, done});
        end
        reset = 1'b0;
        step();
        total++;
        if ({busy, wr_en, done} !== 6'b0) begin
            bad++;
            $display("FAIL idle busy/wr_en/done got=%b exp=000000", {busy, wr_en, done});
        end
    endtask

    task automatic test_staggered();
        int cnt [4] = '{0, 0, 0, 0};
        start = 1'b1; num_rows = 4'd3; stagger = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t <= 8; t++) begin
            total += 3;
            if (busy !== (t < 8)) begin bad++; $display("FAIL stag busy t=%0d got=%b exp=%b", t, busy, t < 8); end
            if (wr_en !== exp_wr(t, 3, 1)) begin bad++; $display("FAIL stag wr_en t=%0d got=%b exp=%b", t, wr_en, exp_wr(t, 3, 1)); end
            if (done !== (t == 8)) begin bad++; $display("FAIL stag done t=%0d got=%b exp=%b", t, done, t == 8); end
            if (t == 5) begin
                total++;
                if (wr_en !== 4'b1110) begin bad++; $display("FAIL stag wr_en_t5 got=%b exp=1110", wr_en); end
            end
            for (int k = 0; k < 4; k++) cnt[k] += int'(wr_en[k]);
            if (t < 8) step();
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (cnt[k] != 3) begin bad++; $display("FAIL stag count col%0d got=%0d exp=3", k, cnt[k]); end
        end
        step();
        total++;
        if ({busy, done} !== 2'b00) begin bad++; $display("FAIL stag after got=%b exp=00", {busy, done}); end
    endtask

    task automatic test_flat();
        int cnt [4] = '{0, 0, 0, 0};
        start = 1'b1; num_rows = 4'd3; stagger = 1'b0;
        step();
        start = 1'b0;
        for (int t = 0; t <= 5; t++) begin
            total += 3;
            if (busy !== (t < 5)) begin bad++; $display("FAIL flat busy t=%0d got=%b exp=%b", t, busy, t < 5); end
            if (wr_en !== ((t >= 2 && t <= 4) ? 4'b1111 : 4'b0000)) begin bad++; $display("FAIL flat wr_en t=%0d got=%b", t, wr_en); end
            if (done !== (t == 5)) begin bad++; $display("FAIL flat done t=%0d got=%b exp=%b", t, done, t == 5); end
            for (int k = 0; k < 4; k++) cnt[k] += int'(wr_en[k]);
            if (t < 5) step();
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (cnt[k] != 3) begin bad++; $display("FAIL flat count col%0d got=%0d exp=3", k, cnt[k]); end
        end
        step();
    endtask

    task automatic test_zero_clamp();
        int cnt [4] = '{0, 0, 0, 0};
        start = 1'b1; num_rows = 4'd0; stagger = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t <= 5; t++) begin
            total += 2;
            if (wr_en !== 4'b0) begin bad++; $display("FAIL zero wr_en t=%0d got=%b exp=0000", t, wr_en); end
            if (done !== (t == 5)) begin bad++; $display("FAIL zero done t=%0d got=%b exp=%b", t, done, t == 5); end
            if (t < 5) step();
        end
        step();
        start = 1'b1; num_rows = 4'd12; stagger = 1'b0;
        step();
        start = 1'b0;
        for (int t = 0; t <= 10; t++) begin
            total += 2;
            if (wr_en !== exp_wr(t, 8, 0)) begin bad++; $display("FAIL clamp wr_en t=%0d got=%b exp=%b", t, wr_en, exp_wr(t, 8, 0)); end
            if (done !== (t == 10)) begin bad++; $display("FAIL clamp done t=%0d got=%b exp=%b", t, done, t == 10); end
            for (int k = 0; k < 4; k++) cnt[k] += int'(wr_en[k]);
            if (t < 10) step();
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (cnt[k] != 8) begin bad++; $display("FAIL clamp count col%0d got=%0d exp=8", k, cnt[k]); end
        end
        step();
    endtask

    task automatic test_back_to_back();
        start = 1'b1; num_rows = 4'd1; stagger = 1'b0;
        step(); step(); step(); step();
        total++;
        if ({busy, done} !== 2'b01) begin bad++; $display("FAIL b2b first_done got=%b exp=01", {busy, done}); end
        step();
        total++;
        if ({busy, wr_en, done} !== 6'b100000) begin bad++; $display("FAIL b2b restart got=%b exp=100000", {busy, wr_en, done}); end
        start = 1'b0;
        step(); step();
        total++;
        if (wr_en !== 4'b1111) begin bad++; $display("FAIL b2b wr_en got=%b exp=1111", wr_en); end
        step();
        total++;
        if ({busy, done} !== 2'b01) begin bad++; $display("FAIL b2b second_done got=%b exp=01", {busy, done}); end
        step();
        total++;
        if ({busy, done} !== 2'b00) begin bad++; $display("FAIL b2b idle got=%b exp=00", {busy, done}); end
    endtask

    task automatic test_ignore();
        start = 1'b1; num_rows = 4'd3; stagger = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t <= 8; t++) begin
            total += 2;
            if (wr_en !== exp_wr(t, 3, 1)) begin bad++; $display("FAIL ignore wr_en t=%0d got=%b exp=%b", t, wr_en, exp_wr(t, 3, 1)); end
            if (done !== (t == 8)) begin bad++; $display("FAIL ignore done t=%0d got=%b exp=%b", t, done, t == 8); end
            start    = (t == 3);
            num_rows = (t == 3) ? 4'd1 : 4'd3;
            stagger  = (t != 3);
            if (t < 8) step();
        end
        start = 1'b0;
        step();
        total++;
        if ({busy, done} !== 2'b00) begin bad++; $display("FAIL ignore after got=%b exp=00", {busy, done}); end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; num_rows = 4'd3; stagger = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        total++;
        if (wr_en !== 4'b0111) begin bad++; $display("FAIL rstmid wr_en_t4 got=%b exp=0111", wr_en); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if ({busy, wr_en, done} !== 6'b0) begin bad++; $display("FAIL rstmid abort got=%b exp=000000", {busy, wr_en, done}); end
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if ({busy, wr_en, done} !== 6'b0) begin bad++; $display("FAIL rstmid quiet i=%0d got=%b exp=000000", i, {busy, wr_en, done}); end
        end
        start = 1'b1; num_rows = 4'd2; stagger = 1'b0;
        step();
        start = 1'b0;
        for (int t = 0; t <= 4; t++) begin
            total += 3;
            if (busy !== (t < 4)) begin bad++; $display("FAIL rstmid busy t=%0d got=%b exp=%b", t, busy, t < 4); end
            if (wr_en !== exp_wr(t, 2, 0)) begin bad++; $display("FAIL rstmid wr_en t=%0d got=%b exp=%b", t, wr_en, exp_wr(t, 2, 0)); end
            if (done !== (t == 4)) begin bad++; $display("FAIL rstmid done t=%0d got=%b exp=%b", t, done, t == 4); end
            if (t < 4) step();
        end
        step();
    endtask

`ifdef MMU_DRAIN_OVF_CHK_EN
    task automatic test_ovf();
        start = 1'b1; num_rows = 4'd3; stagger = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t <= 8; t++) begin
            total++;
            if (ovf_err !== (t >= 5)) begin bad++; $display("FAIL ovf t=%0d got=%b exp=%b", t, ovf_err, t >= 5); end
            fifo_full[2] = (t == 4);
            if (t < 8) step();
        end
        fifo_full[2] = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (ovf_err !== 1'b0) begin bad++; $display("FAIL ovf clear got=%b exp=0", ovf_err); end
        repeat (8) step();
    endtask
`endif

    initial begin
        test_reset();
        test_staggered();
        test_flat();
        test_zero_clamp();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
`ifdef MMU_DRAIN_OVF_CHK_EN
        test_ovf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmu_drain_control.md
Name: mmu_drain_control

Overview:
- Drains matrix-multiply results off the MMU bottom edge into the per-column output FIFO bank.
- Results leave the systolic array as a diagonal wavefront. This block generates the matching staggered per-column write enables so each output FIFO captures exactly its column's result rows.
- Output-side counterpart of the input FIFO load sequencer: the input side skews data into the array, this side captures the skewed results coming out.
- Supports staggered mode (column k lags column k-1 by one cycle) and flat mode (all columns together).

Parameters:
- ARRAY_DIM, 16, number of MMU columns (output FIFOs); width of wr_en.
- ROWS_MAX, 16, maximum result rows per drain.
- START_DELAY, 16, cycles from the first counted cycle until column 0's first result is valid (array fill latency).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a drain; accepted only when busy=0.
- num_rows  input  $clog2(ROWS_MAX+1)  result rows per column; sampled on accept.
- stagger  input  1  1 = staggered wavefront, 0 = flat; sampled on accept.
- busy  output  1  drain in progress.
- wr_en  output  ARRAY_DIM  per-column output FIFO write enable; bit 0 is the leftmost column.
- done  output  1  one-cycle pulse when the drain completes.

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk. All outputs are registered.
- Reset values: busy=0, wr_en=0, done=0, FSM in IDLE, counter=0. A reset asserted mid-drain aborts it at the next edge; no done pulse is produced.
- FSM states: IDLE, DRAIN, FINISH.
  - IDLE: start=1 latches num_rows and stagger (stg = stagger ? 1 : 0), clears t, then goes to DRAIN; busy=1 from the next cycle.
  - DRAIN: t increments by 1 each cycle, starting at t=0 on the first cycle busy=1.
- Write enables: wr_en[k] = 1 exactly when START_DELAY + k*stg <= t < START_DELAY + k*stg + num_rows.
  - Each column therefore receives exactly num_rows enables.
- End of drain: T_END = START_DELAY + (ARRAY_DIM-1)*stg + num_rows.
  - At t == T_END the FSM goes to FINISH: done=1 and busy=0 for that one cycle, then returns to IDLE.
  - start asserted during the FINISH cycle is accepted (back-to-back drains, no idle gap).
- num_rows == 0: wr_en stays 0 throughout; done still pulses at t == START_DELAY + (ARRAY_DIM-1)*stg.
- num_rows > ROWS_MAX: clamped to ROWS_MAX on sample.
- start while busy=1 is ignored; changes to num_rows or stagger mid-drain have no effect.
- Counter width: $clog2(START_DELAY + ARRAY_DIM + ROWS_MAX + 1). The counter never wraps within a drain.

Optional Feature:
- Macro: MMU_DRAIN_OVF_CHK_EN.
- With the macro defined, the block adds:
  - input fifo_full [ARRAY_DIM];
  - output ovf_err (sticky).
  - ovf_err sets the cycle after any k has wr_en[k] & fifo_full[k]. It clears on reset or on the next accepted start. wr_en is unaffected.
- Without the macro: the fifo_full and ovf_err ports and their logic are absent.

Decomposition:
- Shared package tpu_ctrl_pkg holds:
  - FSM state enum drain_state_t {IDLE, DRAIN, FINISH};
  - function for the counter width;
  - default ARRAY_DIM = 16.
- Sub-module drain_col_window: one comparator pair per column (lo/hi bounds vs t) producing wr_en[k]. Instantiated ARRAY_DIM times in a generate loop.

Test Plan (ARRAY_DIM=4, ROWS_MAX=8, START_DELAY=2):
- Staggered: start, num_rows=3, stagger=1 -> wr_en[0] high t=2..4, wr_en[3] high t=5..7; done pulses at t=8; busy high t=0..7.
- Flat: num_rows=3, stagger=0 -> wr_en=4'b1111 for t=2..4; done at t=5; each column gets exactly 3 enables.
- Zero and clamp: num_rows=0 -> wr_en never set, done at t=5 (stagger=1). num_rows=12 -> 8 enables per column.
- Back-to-back and ignore: start held high continuously -> second drain begins the cycle after done with no gap. A start pulse at t=3 while busy is ignored.
- Reset mid-drain: reset at t=4 -> next cycle wr_en=0, busy=0, no done pulse. A fresh start then runs a normal drain.
- With MMU_DRAIN_OVF_CHK_EN: fifo_full[2]=1 at t=4, stagger=1 -> ovf_err=1 from t=5, held until the next start.
